// File: rtl/uart_reg_cmd_ctrl_pkg.sv
// Shared constants for the UART register command sequencer: state encoding,
// protocol bytes and the latched frame layout.
package uart_reg_cmd_ctrl_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_GET_ADDR  = 3'd1;
  localparam logic [2:0] ST_GET_DATA  = 3'd2;
  localparam logic [2:0] ST_DO_WRITE  = 3'd3;
  localparam logic [2:0] ST_DO_READ   = 3'd4;
  localparam logic [2:0] ST_WAIT_READ = 3'd5;
  localparam logic [2:0] ST_SEND      = 3'd6;
  localparam logic [2:0] ST_TX_GUARD  = 3'd7;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  localparam int NUM_REGS = 64;

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] addr;
    logic [7:0] data;
  } frame_t;

  // Full 8-bit compare, so 8'hFF never aliases onto a valid register.
  function automatic logic addr_ok(input logic [7:0] a, input int n);
    return int'({24'd0, a}) < n;
  endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte timeout: reloads on clr, counts down while enabled, and flags
// expiry on the cycle it has sat at zero without being cleared.
module uart_frame_timeout #(
  parameter int CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)                  cnt <= '0;
    else if (clr)               cnt <= LOAD;
    else if (en && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign expire = en & ~clr & (cnt == '0);

endmodule

// File: rtl/uart_reg_cmd_ctrl.sv
// Parses 'W',addr,data / 'R',addr frames from UART RX, drives the register
// file strobes and returns a single response byte to UART TX.
module uart_reg_cmd_ctrl #(
  parameter int NUM_REGS       = uart_reg_cmd_ctrl_pkg::NUM_REGS,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       rf_we,
  output logic [7:0] rf_w_addr,
  output logic [7:0] rf_w_data,
  output logic       rf_re,
  output logic [7:0] rf_r_addr,
  input  logic [7:0] rf_r_data,
  output logic       busy,
  output logic       err_pulse
);
  import uart_reg_cmd_ctrl_pkg::*;

  logic [2:0] state;
  frame_t     frm;
  logic [7:0] rsp;
  logic [7:0] tx_q;
  logic       wait_st, overrun, to_clr, to_exp;

  assign wait_st = (state == ST_GET_ADDR) || (state == ST_GET_DATA);
  assign overrun = rx_valid && !wait_st && (state != ST_IDLE);
  assign to_clr  = ~wait_st | rx_valid;

  uart_frame_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (to_clr),
    .en     (wait_st),
    .expire (to_exp)
  );

  assign busy     = (state != ST_IDLE);
  assign rf_we    = (state == ST_DO_WRITE);
  assign rf_re    = (state == ST_DO_READ);
  assign tx_start = (state == ST_SEND) && !tx_busy;
  // tx_q keeps the last sent byte so tx_data stays put while TX is busy.
  assign tx_data  = tx_start ? rsp : tx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      frm       <= '0;
      rsp       <= '0;
      tx_q      <= '0;
      rf_w_addr <= '0;
      rf_w_data <= '0;
      rf_r_addr <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= overrun;
      case (state)
        ST_IDLE: if (rx_valid) begin
          if (rx_data == CMD_WR || rx_data == CMD_RD) begin
            frm.cmd <= rx_data;
            state   <= ST_GET_ADDR;
          end else begin
            rsp       <= RSP_ERR;
            err_pulse <= 1'b1;
            state     <= ST_SEND;
          end
        end
        ST_GET_ADDR: begin
          if (rx_valid) begin
            frm.addr <= rx_data;
            if (frm.cmd == CMD_WR) begin
              state <= ST_GET_DATA;
            end else if (addr_ok(rx_data, NUM_REGS)) begin
              rf_r_addr <= rx_data;
              state     <= ST_DO_READ;
            end else begin
              rsp       <= RSP_ERR;
              err_pulse <= 1'b1;
              state     <= ST_SEND;
            end
          end else if (to_exp) begin
            frm       <= '0;
            err_pulse <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_GET_DATA: begin
          if (rx_valid) begin
            frm.data <= rx_data;
            if (addr_ok(frm.addr, NUM_REGS)) begin
              rf_w_addr <= frm.addr;
              rf_w_data <= rx_data;
              state     <= ST_DO_WRITE;
            end else begin
              rsp       <= RSP_ERR;
              err_pulse <= 1'b1;
              state     <= ST_SEND;
            end
          end else if (to_exp) begin
            frm       <= '0;
            err_pulse <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_DO_WRITE: begin
          rsp   <= RSP_ACK;
          state <= ST_SEND;
        end
        ST_DO_READ:  state <= ST_WAIT_READ;
        ST_WAIT_READ: begin
          rsp   <= rf_r_data;
          state <= ST_SEND;
        end
        ST_SEND: if (!tx_busy) begin
          tx_q  <= rsp;
          state <= ST_TX_GUARD;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_cmd_ctrl.sv
// Directed bench: stimulus pushes expected events (with expected cycle) into a
// queue; a negedge monitor pops and compares every strobe the DUT raises.
module tb_uart_reg_cmd_ctrl;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       rf_we, rf_re, busy, err_pulse;
  logic [7:0] rf_w_addr, rf_w_data, rf_r_addr;
  logic [7:0] rf_r_data = 8'h00;

  always #5 clk = ~clk;

  uart_reg_cmd_ctrl #(.NUM_REGS(64), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start),
    .rf_we(rf_we), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
    .rf_re(rf_re), .rf_r_addr(rf_r_addr), .rf_r_data(rf_r_data),
    .busy(busy), .err_pulse(err_pulse)
  );

  // register file and UART TX models
  logic [7:0] mem [64] = '{default: 8'h00};
  always @(posedge clk) begin
    if (rf_we && rf_w_addr < 8'd64) mem[rf_w_addr[5:0]] <= rf_w_data;
    if (rf_re) rf_r_data <= mem[rf_r_addr[5:0]];
  end

  int   ucnt = 0;
  logic force_busy = 1'b0;
  always @(posedge clk) begin
    if (tx_start) ucnt <= 4;
    else if (ucnt != 0) ucnt <= ucnt - 1;
  end
  assign tx_busy = force_busy | (ucnt != 0);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kinds: 0 err_pulse, 1 rf_we, 2 rf_re, 3 tx_start
  typedef struct {
    int         kind;
    logic [7:0] a;
    logic [7:0] d;
    int         c;
  } ev_t;
  ev_t exp_q[$];
  int  n_tests = 0, n_fail = 0;

  function automatic void expect_ev(int kind, logic [7:0] a, logic [7:0] d, int c);
    ev_t e;
    e.kind = kind; e.a = a; e.d = d; e.c = c;
    exp_q.push_back(e);
  endfunction

  task automatic chk_ev(int kind, logic [7:0] a, logic [7:0] d);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d a=%h d=%h cyc=%0d, expected none",
               kind, a, d, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.a != a || e.d != d || e.c != cyc) begin
        n_fail++;
        $display("FAIL event: got kind=%0d a=%h d=%h cyc=%0d, expected kind=%0d a=%h d=%h cyc=%0d",
                 kind, a, d, cyc, e.kind, e.a, e.d, e.c);
      end
    end
  endtask

  always @(negedge clk) begin
    if (err_pulse) chk_ev(0, 8'h00, 8'h00);
    if (rf_we)     chk_ev(1, rf_w_addr, rf_w_data);
    if (rf_re)     chk_ev(2, rf_r_addr, 8'h00);
    if (tx_start)  chk_ev(3, 8'h00, tx_data);
  end

  task automatic chk_zero(input string name);
    logic [42:0] v;
    v = {tx_data, tx_start, rf_we, rf_w_addr, rf_w_data, rf_re, rf_r_addr, busy, err_pulse};
    n_tests++;
    if (v != '0) begin
      n_fail++;
      $display("FAIL %s: outputs=%h, expected all zero", name, v);
    end
  endtask

  // returns the cycle index of the clock edge that sampled the byte
  task automatic send_byte(input logic [7:0] b, output int n);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    n = cyc;
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, k;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_state");
    reset = 1'b0;
    idle(2);

    // write 0xAB to reg 5
    send_byte(8'h57, n); send_byte(8'h05, n); send_byte(8'hAB, n);
    expect_ev(1, 8'h05, 8'hAB, n);
    expect_ev(3, 8'h00, 8'h4B, n + 1);
    idle(8);

    // read it back: tx 3 cycles after the addr byte's rx_valid
    send_byte(8'h52, n); send_byte(8'h05, n);
    expect_ev(2, 8'h05, 8'h00, n);
    expect_ev(3, 8'h00, 8'hAB, n + 2);
    idle(8);

    // write to addr 70: data byte consumed, error response
    send_byte(8'h57, n); send_byte(8'h46, n); send_byte(8'hFF, n);
    expect_ev(0, 8'h00, 8'h00, n);
    expect_ev(3, 8'h00, 8'h45, n);
    idle(8);

    // read of addr 70 and addr 255
    send_byte(8'h52, n); send_byte(8'h46, n);
    expect_ev(0, 8'h00, 8'h00, n);
    expect_ev(3, 8'h00, 8'h45, n);
    idle(8);
    send_byte(8'h52, n); send_byte(8'hFF, n);
    expect_ev(0, 8'h00, 8'h00, n);
    expect_ev(3, 8'h00, 8'h45, n);
    idle(8);

    // bad command byte in IDLE
    send_byte(8'h41, n);
    expect_ev(0, 8'h00, 8'h00, n);
    expect_ev(3, 8'h00, 8'h45, n);
    idle(8);

    // timeout after the command byte: err only, no response
    send_byte(8'h57, n);
    expect_ev(0, 8'h00, 8'h00, n + TO);
    idle(TO + 6);

    // normal frame afterwards, plus a read of the freshly written reg 63
    send_byte(8'h57, n); send_byte(8'h3F, n); send_byte(8'h3C, n);
    expect_ev(1, 8'h3F, 8'h3C, n);
    expect_ev(3, 8'h00, 8'h4B, n + 1);
    idle(8);
    send_byte(8'h52, n); send_byte(8'h3F, n);
    expect_ev(2, 8'h3F, 8'h00, n);
    expect_ev(3, 8'h00, 8'h3C, n + 2);
    idle(8);

    // TX held busy in SEND; an overrun byte arrives while waiting
    @(posedge clk); #1;
    force_busy = 1'b1;
    send_byte(8'h41, n);
    expect_ev(0, 8'h00, 8'h00, n);
    idle(3);
    send_byte(8'h52, m);
    expect_ev(0, 8'h00, 8'h00, m);
    while (cyc < n + 20) begin
      @(posedge clk); #1;
    end
    force_busy = 1'b0;
    k = cyc;
    expect_ev(3, 8'h00, 8'h45, k);
    idle(8);

    // write 0x77 to reg 3, then abort a second write to reg 3 with reset
    send_byte(8'h57, n); send_byte(8'h03, n); send_byte(8'h77, n);
    expect_ev(1, 8'h03, 8'h77, n);
    expect_ev(3, 8'h00, 8'h4B, n + 1);
    idle(8);
    send_byte(8'h57, n); send_byte(8'h03, n);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk_zero("mid_frame_reset");
    reset = 1'b0;
    // a data byte after the abort is a bad command, not a write
    send_byte(8'h55, n);
    expect_ev(0, 8'h00, 8'h00, n);
    expect_ev(3, 8'h00, 8'h45, n);
    idle(8);
    send_byte(8'h52, n); send_byte(8'h03, n);
    expect_ev(2, 8'h03, 8'h00, n);
    expect_ev(3, 8'h00, 8'h77, n + 2);
    idle(10);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: %0d expected events never seen, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_reg_cmd_ctrl.md
Name: uart_reg_cmd_ctrl

Overview:
- Command sequencer between the UART RX/TX byte interfaces and the 64-entry register_file.
- Parses binary frames from UART RX: write frame = 'W', addr, data; read frame = 'R', addr.
- Drives the register_file write/read strobes and returns one response byte to UART TX.
- Sole master of the register_file port; the TX byte is requested with a single-cycle start pulse.

Parameters:
NUM_REGS, 64, number of valid register addresses; addr >= NUM_REGS is invalid
TIMEOUT_CYCLES, 100000, max idle clocks between bytes of one frame before abort
CMD_WR, 8'h57, write command byte ('W')
CMD_RD, 8'h52, read command byte ('R')
RSP_ACK, 8'h4B, write-success response ('K')
RSP_ERR, 8'h45, error response ('E')

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_data  in  8  received byte, valid only with rx_valid
rx_valid  in  1  one-cycle strobe, new RX byte
tx_busy  in  1  UART TX busy; rises no later than 1 cycle after tx_start
tx_data  out  8  response byte, held stable while tx_busy=1
tx_start  out  1  one-cycle pulse requesting transmission of tx_data
rf_we  out  1  register_file write enable, one-cycle pulse
rf_w_addr  out  8  register_file write address
rf_w_data  out  8  register_file write data
rf_re  out  1  register_file read enable, one-cycle pulse
rf_r_addr  out  8  register_file read address
rf_r_data  in  8  register_file read data, valid 1 cycle after rf_re
busy  out  1  high in every state except IDLE
err_pulse  out  1  one-cycle pulse on timeout, overrun, bad command or bad address

Behaviour:
- Reset: state=IDLE. All outputs 0: tx_data, tx_start, rf_we, rf_re, rf_w_addr, rf_w_data, rf_r_addr, busy, err_pulse. Timeout counter=0, latched cmd/addr/data=0. Reset mid-frame or mid-TX aborts immediately; no pending write is committed.
- State IDLE: on rx_valid:
  - rx_data==CMD_WR or CMD_RD: latch cmd, go GET_ADDR.
  - Any other byte: load RSP_ERR, pulse err_pulse, go SEND.
- State GET_ADDR: on rx_valid, latch addr.
  - cmd=WR: go GET_DATA.
  - cmd=RD and addr<NUM_REGS: go DO_READ.
  - cmd=RD and addr>=NUM_REGS: load RSP_ERR, pulse err_pulse, go SEND.
- State GET_DATA: on rx_valid, latch data.
  - addr<NUM_REGS: go DO_WRITE.
  - Otherwise: load RSP_ERR, pulse err_pulse, go SEND. The data byte is consumed and no write occurs.
- State DO_WRITE: one cycle with rf_we=1, rf_w_addr=addr, rf_w_data=data. Load RSP_ACK, go SEND.
- State DO_READ: one cycle with rf_re=1, rf_r_addr=addr. Go WAIT_READ.
- State WAIT_READ: one cycle; capture rf_r_data as the response byte. Go SEND.
- rf_w_addr, rf_w_data and rf_r_addr hold their last values when the strobes are low.
- State SEND: when tx_busy=0, drive tx_data=response and tx_start=1 for one cycle, go TX_GUARD. While tx_busy=1, wait.
- State TX_GUARD: one cycle, tx_busy ignored. Go IDLE.
- Timeout: the counter runs only in GET_ADDR and GET_DATA and clears on every rx_valid and on any state change. When it reaches TIMEOUT_CYCLES-1:
  - pulse err_pulse, discard the frame, go IDLE;
  - no response byte is sent.
- Overrun: rx_valid in DO_WRITE, DO_READ, WAIT_READ, SEND or TX_GUARD drops the byte and pulses err_pulse. The state sequence is unaffected.
- Simultaneous events: a timeout and rx_valid in the same cycle resolve in favour of the byte; there is no timeout.
- Latency: rf_we asserts 1 cycle after the data byte's rx_valid. tx_start asserts 1 cycle after rf_we, assuming tx_busy=0. For a read, tx_start asserts 3 cycles after the addr byte's rx_valid.
- The address compare uses the full 8 bits; 255 is invalid.

Decomposition:
- Shared package/header holds:
  - the state encoding (3-bit localparams: IDLE, GET_ADDR, GET_DATA, DO_WRITE, DO_READ, WAIT_READ, SEND, TX_GUARD);
  - the CMD_* and RSP_* byte constants;
  - NUM_REGS.
- One natural sub-module: uart_frame_timeout. It is a loadable down-counter with clear/enable inputs and an expire output.

Test Plan:
- Reset, then frame 0x57,0x05,0xAB -> rf_we for one cycle with addr=5, data=0xAB; tx_start with tx_data=0x4B; err_pulse stays 0.
- After the write above, frame 0x52,0x05, with the register_file model returning 0xAB -> rf_re for one cycle with addr=5; tx_data=0xAB on tx_start 3 cycles after the addr byte.
- Frame 0x57,0x46,0xFF (addr 70) -> no rf_we; err_pulse=1; tx_data=0x45. Then 0x52,0x46 -> no rf_re; tx_data=0x45.
- Byte 0x41 in IDLE -> tx_data=0x45 and err_pulse. Byte 0x57 followed by TIMEOUT_CYCLES=16 idle clocks -> err_pulse, return to IDLE, no tx_start. A following valid frame works normally.
- Hold tx_busy=1 for 20 cycles during SEND -> tx_start delayed until tx_busy=0. An rx_valid during SEND -> err_pulse; the byte is ignored and the response is unchanged.
- Assert reset in GET_DATA after 0x57,0x03 -> all outputs 0 next cycle, no write to reg 3. A subsequent read of reg 3 returns its old value.
